// File: rtl/przesuniecie_pkg.sv
// ============================================================================
// Module  : przesuniecie_pkg
// Brief   : Shared constants and core-to-register result type for the
//           arithmetic left-shift unit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package przesuniecie_pkg;

    localparam int DEF_BITS = 32;
    localparam int SHAMT_W  = $clog2(DEF_BITS);

    // Result bundle is sized by DEF_BITS; retarget the width here.
    typedef struct packed {
        logic [DEF_BITS-1:0] result;
        logic                error;
        logic                overflow;
    } shift_res_t;

endpackage

`default_nettype wire

// File: rtl/przesuniecie_core.sv
// ============================================================================
// Module  : przesuniecie_core
// Brief   : Combinational signed left shift with error/overflow flags and
//           optional saturation (enabled by PRZESUNIECIE_SAT_EN).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module przesuniecie_core
    import przesuniecie_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] arg_a_i,
    input  logic [BITS-1:0] arg_b_i,
    output shift_res_t      res_o
);

    localparam int C_SHAMT_W = (BITS > 1) ? $clog2(BITS) : 1;

    logic                 w_neg;
    logic                 w_big;
    logic [C_SHAMT_W-1:0] w_shamt;
    logic [BITS-1:0]      w_shl;
    logic [BITS-1:0]      w_back;

    assign w_neg   = arg_b_i[BITS-1];
    // Range check on the full shift amount, not just its low bits.
    assign w_big   = ({1'b0, arg_b_i} >= (BITS+1)'(BITS));
    assign w_shamt = arg_b_i[C_SHAMT_W-1:0];
    assign w_shl   = arg_a_i << w_shamt;
    assign w_back  = $signed(w_shl) >>> w_shamt;

    always_comb begin
        res_o = '0;
        if (w_neg) begin
            res_o.error = 1'b1;
        end else if (w_big) begin
            res_o.overflow = |arg_a_i;
        end else begin
            res_o.result   = w_shl;
            res_o.overflow = (w_back != arg_a_i);
        end
`ifdef PRZESUNIECIE_SAT_EN
        if (res_o.overflow) begin
            res_o.result = arg_a_i[BITS-1] ? {1'b1, {(BITS-1){1'b0}}}
                                           : {1'b0, {(BITS-1){1'b1}}};
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/przesuniecie_arytmetyczne.sv
// ============================================================================
// Module  : przesuniecie_arytmetyczne
// Brief   : Registered arithmetic left shift (latency 1), o_result = A <<< B.
//           Define PRZESUNIECIE_SAT_EN to saturate on overflow.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module przesuniecie_arytmetyczne
    import przesuniecie_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_overflow
);

    shift_res_t res_d;
    shift_res_t res_q;

    przesuniecie_core #(
        .BITS    (BITS)
    ) u_core (
        .arg_a_i (i_arg_A),
        .arg_b_i (i_arg_B),
        .res_o   (res_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign o_result   = res_q.result;
    assign o_error    = res_q.error;
    assign o_overflow = res_q.overflow;

endmodule

`default_nettype wire

// File: tb/tb_przesuniecie_arytmetyczne.sv
// ============================================================================
// Module  : tb_przesuniecie_arytmetyczne
// Brief   : Scoreboard bench for przesuniecie_arytmetyczne against an
//           integer-arithmetic reference model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_przesuniecie_arytmetyczne;

    localparam int BITS = 32;

    typedef struct {
        logic [BITS-1:0] r;
        logic            e;
        logic            o;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [BITS-1:0] arg_a;
    logic [BITS-1:0] arg_b;
    logic [BITS-1:0] result;
    logic            error;
    logic            overflow;

    exp_t q[$];
    int   n_checks;
    int   n_pass;

    przesuniecie_arytmetyczne #(
        .BITS       (BITS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_arg_A    (arg_a),
        .i_arg_B    (arg_b),
        .o_result   (result),
        .o_error    (error),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifting is modelled as multiplication by 2**B in 64-bit arithmetic.
    function automatic exp_t model(logic [BITS-1:0] a, logic [BITS-1:0] b);
        exp_t   x;
        longint sa;
        longint p;
        sa  = longint'($signed(a));
        x.r = '0;
        x.e = 1'b0;
        x.o = 1'b0;
        if ($signed(b) < 0) begin
            x.e = 1'b1;
        end else if (b >= 32'(BITS)) begin
            x.o = (sa != 0);
        end else begin
            p   = sa * (longint'(2) ** b);
            x.r = p[BITS-1:0];
            x.o = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end
`ifdef PRZESUNIECIE_SAT_EN
        if (x.o) x.r = (sa > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return x;
    endfunction

    task automatic drive(input logic r, input logic [BITS-1:0] a,
                         input logic [BITS-1:0] b);
        exp_t z;
        @(negedge clk);
        rst_n = r;
        arg_a = a;
        arg_b = b;
        if (!r) begin
            z.r = '0; z.e = 1'b0; z.o = 1'b0;
            q.push_back(z);
        end else begin
            q.push_back(model(a, b));
        end
    endtask

    function automatic logic [BITS-1:0] rnd_a();
        logic [BITS-1:0] v;
        v = $urandom();
        if (v == 32'h8000_0000) v = 32'h8000_0001;
        return v;
    endfunction

    // Monitor: one registered output per cycle, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (result === e.r && error === e.e && overflow === e.o) begin
                    n_pass++;
                end else begin
                    $display("FAIL shift_out: got r=%h e=%b o=%b, expected r=%h e=%b o=%b",
                             result, error, overflow, e.r, e.e, e.o);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        arg_a    = 32'd5;
        arg_b    = 32'd1;

        #2;
        n_checks++;
        if (result === '0 && error === 1'b0 && overflow === 1'b0) n_pass++;
        else $display("FAIL reset_async: got r=%h e=%b o=%b, expected all 0",
                      result, error, overflow);

        repeat (3) drive(1'b0, 32'd5, 32'd1);
        drive(1'b1, 32'd5, 32'd1);

        drive(1'b1, 32'd3, 32'd4);
        drive(1'b1, -32'sd3, 32'd4);
        drive(1'b1, 32'h0000_FFFF, 32'd15);
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_a(), 32'($urandom_range(0, 31)));

        for (int i = 0; i < 5; i++) drive(1'b1, rnd_a(), 32'd0);

        drive(1'b1, rnd_a(), 32'hFFFF_FFFF);
        drive(1'b1, rnd_a(), 32'h8000_0001);

        drive(1'b1, 32'd0, 32'd32);
        drive(1'b1, 32'd0, 32'd34);
        drive(1'b1, 32'd1, 32'd31);
        drive(1'b1, 32'hFFFF_FFFF, 32'd31);
        drive(1'b1, 32'd1, 32'd34);
        drive(1'b1, 32'h8000_0000, 32'd1);
        drive(1'b1, 32'h8000_0000, 32'd40);
        drive(1'b1, 32'h4000_0000, 32'd1);
        drive(1'b1, 32'd5, 32'h4000_0003);

        for (int i = 0; i < 10; i++) begin
            logic [BITS-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? 32'($urandom() | 32'h8000_0000)
                                             : 32'($urandom_range(0, 40));
            drive(1'b1, rnd_a(), b);
        end

        drive(1'b0, 32'd7, 32'd2);
        drive(1'b1, 32'd7, 32'd2);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/przesuniecie_arytmetyczne.md
Name: przesuniecie_arytmetyczne

Overview:
- Registered arithmetic left-shift unit for the synchronous arithmetic unit: o_result = i_arg_A <<< i_arg_B.
- Both operands are signed two's-complement.
- Raises o_error for a negative shift amount and o_overflow when significant bits or the sign would be lost.
- One of several operation blocks selected by the arithmetic unit's top level; outputs are registered, latency 1 cycle.

Parameters:
- BITS, 32, width of operands and result (minimum 2).

Ports:
- i_clk  in  1  system clock, rising edge active
- i_rst_n  in  1  asynchronous active-low reset
- i_arg_A  in  BITS  signed value to shift
- i_arg_B  in  BITS  signed shift amount
- o_result  out  BITS  signed shifted result (registered)
- o_error  out  1  shift amount negative (registered)
- o_overflow  out  1  result not representable (registered)

Behaviour:
- Reset: i_rst_n low asynchronously clears o_result, o_error and o_overflow to 0. Release is synchronous to the next i_clk edge.
- Every rising i_clk edge samples the inputs; outputs reflect those inputs after exactly 1 cycle. There is no handshake and no enable; a new operation is accepted every cycle.
- Case B < 0 (i_arg_B[BITS-1]=1): o_error=1, o_overflow=0, o_result=0.
- Case 0 <= B <= BITS-1: o_result = A shifted left by B, zero-filled at the LSB, truncated to BITS bits. o_error=0.
  - o_overflow=1 iff the arithmetic right shift of the truncated result by B differs from A. This means any discarded bit, or the new sign bit, differs from A's original sign.
- Case B >= BITS (positive): o_result=0, o_error=0, o_overflow = (A != 0).
- B=0: o_result=A, both flags 0.
- A=0: o_result=0 and o_overflow=0 for every non-negative B, including B >= BITS.
- Most-negative A (1 followed by zeros): o_overflow=1 for any B >= 1.
- The overflow check must use the full BITS-wide B; it must not be truncated to log2(BITS) bits.
- Reset asserted mid-operation discards the in-flight result; the first valid output after release comes 1 cycle after the first sampled edge.
- Flags are mutually exclusive: never o_error=1 and o_overflow=1 together.

Optional Feature:
- Macro: PRZESUNIECIE_SAT_EN.
- Defined: when o_overflow=1, o_result saturates instead of wrapping.
  - To 2**(BITS-1)-1 if A > 0.
  - To -2**(BITS-1) if A < 0.
  - Error behaviour is unchanged; a negative B still gives o_result=0.
- Undefined: o_result is the truncated (wrapped) value described in Behaviour.
- Flag outputs are identical in both builds.

Decomposition:
- Package przesuniecie_pkg holds:
  - the BITS default constant;
  - the derived constant SHAMT_W = $clog2(BITS);
  - a packed struct shift_res_t {result, error, overflow} used between the core and the register stage.
- Sub-module przesuniecie_core: purely combinational shift, flag and (optional) saturation logic producing shift_res_t.
- Top level: instantiates the core plus one output register bank with asynchronous active-low reset.

Test Plan:
- Reset: hold i_rst_n=0 with A=5, B=1 and toggle the clock -> all outputs 0. Release -> one cycle later o_result=10, flags 0.
- Nominal shifts: A=3,B=4 -> 48. A=-3,B=4 -> -48. A=0x0000_FFFF,B=15 -> 0x7FFF_8000. No flags. Plus 5 random A in ±(2**31-1) with random B in 0..31, compared to a reference model including overflow.
- Zero shift: 5 random A with B=0 -> o_result=A, flags 0, 1-cycle latency.
- Negative shift: A random, B=-1 and B=-(2**31-1) -> o_error=1, o_overflow=0, o_result=0.
- Boundary and overflow:
  - A=0 with B=32 and B=34 -> result 0, no flags.
  - A=1, B=31 -> overflow.
  - A=-1, B=31 -> result 0x8000_0000, no overflow.
  - A=1, B=34 -> o_overflow=1, o_result=0 (0x7FFF_FFFF with PRZESUNIECIE_SAT_EN).
- Back-to-back: change A and B every cycle over 10 cycles -> each output equals the model of the inputs from the previous cycle, with no bubbles.
